// File: rtl/mmix_mem_responder.sv
// mmix_mem_responder: MMIX memory-bus responder that splits byte/wyde/tetra/octa
// accesses into big-endian 16-bit RAM beats. Optional ack timeout: MMIX_MEM_TIMEOUT_EN.
module mmix_mem_responder #(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       mem_address,
    input  logic [1:0]        mem_datasize,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [63:0]       mem_writedata,
    output logic [63:0]       mem_readdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [1:0]        ram_be,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic              ram_ack
`ifdef MMIX_MEM_TIMEOUT_EN
    ,
    output logic              mem_timeout
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              lsb_q, lsb_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [1:0]        beat_q, beat_d;
    logic [47:0]       rbuf_q, rbuf_d;
    logic [63:0]       rdata_q, rdata_d;

    logic [1:0]        last_beat;
    logic [1:0]        word_sel;
    logic              beat_done;
    logic [15:0]       rd_word;

    // Upper address bits alias the whole RAM, so they are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address[63:ADDR_W+1];

`ifdef MMIX_MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic          tmo_hit;

    // A beat that has waited TIMEOUT cycles completes on its own with all-ones data.
    assign tmo_hit     = (state_q == ST_ACCESS) && !ram_ack && (tmo_cnt_q == TW'(TIMEOUT));
    assign beat_done   = ram_ack || tmo_hit;
    assign rd_word     = ram_ack ? ram_rdata : 16'hFFFF;
    assign mem_timeout = tmo_flag_q;

    always_comb begin
        tmo_flag_d = tmo_flag_q | tmo_hit;
        tmo_cnt_d  = tmo_cnt_q;
        if ((state_q != ST_ACCESS) || beat_done) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end
`else
    assign beat_done = ram_ack;
    assign rd_word   = ram_rdata;
`endif

    always_comb begin
        case (size_q)
            2'd2:    last_beat = 2'd1;
            2'd3:    last_beat = 2'd3;
            default: last_beat = 2'd0;
        endcase
    end

    // Beat 0 carries the most significant word of the access.
    assign word_sel     = last_beat - beat_q;
    assign mem_readdata = rdata_q;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        size_d    = size_q;
        write_d   = write_q;
        lsb_d     = lsb_q;
        wdata_d   = wdata_q;
        beat_d    = beat_q;
        rbuf_d    = rbuf_q;
        rdata_d   = rdata_q;
        mem_done  = 1'b0;
        ram_rd    = 1'b0;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_be    = 2'b00;
        ram_wdata = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                if (mem_write || mem_read) begin
                    write_d = mem_write;
                    size_d  = mem_datasize;
                    lsb_d   = mem_address[0];
                    wdata_d = mem_writedata;
                    beat_d  = 2'd0;
                    rbuf_d  = '0;
                    case (mem_datasize)
                        2'd2:    base_d = {mem_address[ADDR_W:2], 1'b0};
                        2'd3:    base_d = {mem_address[ADDR_W:3], 2'b00};
                        default: base_d = mem_address[ADDR_W:1];
                    endcase
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                ram_rd   = !write_q;
                ram_wr   = write_q;
                ram_addr = base_q + ADDR_W'(beat_q);
                if (size_q == 2'd0) begin
                    ram_be    = lsb_q ? 2'b01 : 2'b10;
                    ram_wdata = {wdata_q[7:0], wdata_q[7:0]};
                end else begin
                    ram_be    = 2'b11;
                    ram_wdata = wdata_q[{word_sel, 4'b0000} +: 16];
                end

                if (beat_done) begin
                    if (!write_q) begin
                        rbuf_d = {rbuf_q[31:0], rd_word};
                    end
                    if (beat_q == last_beat) begin
                        state_d = ST_DONE;
                        if (!write_q) begin
                            if (size_q == 2'd0) begin
                                rdata_d = {56'd0, lsb_q ? rd_word[7:0] : rd_word[15:8]};
                            end else begin
                                rdata_d = {rbuf_q, rd_word};
                            end
                        end
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end

            ST_DONE: begin
                mem_done = 1'b1;
                state_d  = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            lsb_q   <= 1'b0;
            wdata_q <= 64'd0;
            beat_q  <= 2'd0;
            rbuf_q  <= 48'd0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            size_q  <= size_d;
            write_q <= write_d;
            lsb_q   <= lsb_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mmix_mem_responder.sv
// tb_mmix_mem_responder: randomized scoreboard bench with a wait-stated RAM emulator
// and a byte-level reference memory for mmix_mem_responder.
module tb_mmix_mem_responder;

`ifdef MMIX_MEM_TIMEOUT_EN
    localparam int TMO_P = 4;
`else
    localparam int TMO_P = 255;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] mem_address = 64'd0;
    logic [1:0]  mem_datasize = 2'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] mem_writedata = 64'd0;
    logic [63:0] mem_readdata;
    logic        mem_done;
    logic [19:0] ram_addr;
    logic        ram_rd;
    logic        ram_wr;
    logic [1:0]  ram_be;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'd0;
    logic        ram_ack = 1'b0;
`ifdef MMIX_MEM_TIMEOUT_EN
    logic        mem_timeout;
`endif

    mmix_mem_responder #(.ADDR_W(20), .TIMEOUT(TMO_P)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_address   (mem_address),
        .mem_datasize  (mem_datasize),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_done      (mem_done),
        .ram_addr      (ram_addr),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .ram_be        (ram_be),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .ram_ack       (ram_ack)
`ifdef MMIX_MEM_TIMEOUT_EN
        ,
        .mem_timeout   (mem_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [63:0] val;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic [19:0] addr;
        logic [1:0]  be;
        bit          wr;
        logic [15:0] wdata;
    } beat_t;

    exp_t        sb[$];
    beat_t       bq[$];
    logic [15:0] bram [0:255];
    logic [7:0]  rmem [0:511];
    logic [63:0] exp_last = 64'd0;
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          wait_fixed = 0;
    bit          no_ack = 1'b0;
    int          acks_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_word(input int w, input logic [15:0] v);
        bram[w]       = v;
        rmem[2*w]     = v[15:8];
        rmem[2*w + 1] = v[7:0];
    endtask

    function automatic logic [63:0] ref_read(input logic [8:0] base, input int nb);
        logic [63:0] v = 64'd0;
        for (int j = 0; j < nb; j++) v = (v << 8) | 64'(rmem[9'(base + 9'(j))]);
        return v;
    endfunction

    // Expected RAM beats for one access, derived from byte-level big-endian layout.
    task automatic push_beats(input bit wr, input int sz, input logic [8:0] base, input logic [63:0] wval);
        beat_t b;
        int    nb = 1 << sz;
        if (sz == 0) begin
            b.addr = 20'(base >> 1);
            b.be = base[0] ? 2'b01 : 2'b10;
            b.wr = wr;
            b.wdata = {wval[7:0], wval[7:0]};
            bq.push_back(b);
        end else begin
            for (int k = 0; k < nb / 2; k++) begin
                b.addr  = 20'(base >> 1) + 20'(k);
                b.be    = 2'b11;
                b.wr    = wr;
                b.wdata = 16'(wval >> ((nb - 2 - 2 * k) * 8));
                bq.push_back(b);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Wait-stated RAM emulator: acks after wait_fixed (or random) cycles and checks each beat.
    initial begin
        int          wcnt;
        int          cur_wait;
        bit          active;
        logic [19:0] a_hold;
        logic [1:0]  be_hold;
        logic [15:0] wd_hold;
        beat_t       b;
        active = 1'b0;
        wcnt = 0;
        cur_wait = 0;
        forever begin
            @(negedge clk);
            ram_ack   = 1'b0;
            ram_rdata = 16'($urandom);
            if (!reset_n) begin
                active = 1'b0;
            end else if (ram_rd || ram_wr) begin
                if (!active) begin
                    active   = 1'b1;
                    wcnt     = 0;
                    a_hold   = ram_addr;
                    be_hold  = ram_be;
                    wd_hold  = ram_wdata;
                    cur_wait = (wait_fixed < 0) ? int'($urandom_range(3)) : wait_fixed;
                end else begin
                    check("hold_addr", 64'(ram_addr), 64'(a_hold));
                    check("hold_be", 64'(ram_be), 64'(be_hold));
                    check("hold_wdata", 64'(ram_wdata), 64'(wd_hold));
                end
                if (!no_ack && wcnt == cur_wait) begin
                    if (bq.size() == 0) begin
                        checks++;
                        $display("FAIL beat_unexpected: addr %h with no beat expected", ram_addr);
                    end else begin
                        b = bq.pop_front();
                        check("beat_addr", 64'(ram_addr), 64'(b.addr));
                        check("beat_be", 64'(ram_be), 64'(b.be));
                        check("beat_dir", 64'(ram_wr), 64'(b.wr));
                        if (b.wr) check("beat_wdata", 64'(ram_wdata), 64'(b.wdata));
                    end
                    if (ram_wr) begin
                        if (ram_be[1]) bram[ram_addr[7:0]][15:8] = ram_wdata[15:8];
                        if (ram_be[0]) bram[ram_addr[7:0]][7:0]  = ram_wdata[7:0];
                    end else begin
                        ram_rdata = bram[ram_addr[7:0]];
                    end
                    ram_ack = 1'b1;
                    acks_total++;
                    active = 1'b0;
                end else begin
                    wcnt++;
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    // Monitor: pops one expectation per mem_done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && mem_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: mem_done=1 with no access outstanding");
                end else begin
                    e = sb.pop_front();
                    $display("txn %s readdata=%h cyc=%0d", e.is_read ? "rd" : "wr", mem_readdata, cyc);
                    check(e.is_read ? "read_data" : "readdata_held", mem_readdata, e.val);
                    if (e.done_cyc >= 0) check("latency", 64'(cyc), 64'(e.done_cyc));
                end
            end
        end
    end

    task automatic do_op(input bit wr, input bit rd, input int sz, input logic [63:0] addr,
                         input logic [63:0] wval, input int w);
        int          nb = 1 << sz;
        int          nbeats = (sz < 2) ? 1 : (1 << sz) / 2;
        logic [8:0]  base = 9'(addr[8:0] & 9'(~(nb - 1)));
        exp_t        e;
        bit          got;
        wait_fixed = w;
        push_beats(wr, sz, base, wval);
        e.is_read = !wr;
        if (wr) begin
            for (int j = 0; j < nb; j++) rmem[9'(base + 9'(j))] = 8'(wval >> ((nb - 1 - j) * 8));
            e.val = exp_last;
        end else begin
            e.val = no_ack ? 64'hFFFF : ref_read(base, nb);
            exp_last = e.val;
        end
        if (no_ack) e.done_cyc = cyc + nbeats * (TMO_P + 1) + 1;
        else if (w >= 0) e.done_cyc = cyc + nbeats * (w + 1) + 1;
        else e.done_cyc = -1;
        sb.push_back(e);
        mem_address = addr;
        mem_datasize = 2'(sz);
        mem_write = wr;
        mem_read = rd;
        mem_writedata = wval;
        @(posedge clk);
        #1;
        mem_address = {$urandom, $urandom};
        mem_writedata = {$urandom, $urandom};
        mem_datasize = 2'($urandom_range(3));
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = mem_done;
        end
        if (!got) begin
            checks++;
            $display("FAIL done_timeout: no mem_done within 400 cycles, required 1");
            sb.delete();
            bq.delete();
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check("done_pulse", 64'(mem_done), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] wv;
        int          a0;
        bit          hit;
        for (int w = 0; w < 256; w++) set_word(w, 16'($urandom));
        set_word(4, 16'h1122);
        set_word(5, 16'h3344);
        set_word(6, 16'h5566);
        set_word(7, 16'h7788);
        repeat (3) @(negedge clk);
        check("rst_done", 64'(mem_done), 64'd0);
        check("rst_rd", 64'(ram_rd), 64'd0);
        check("rst_wr", 64'(ram_wr), 64'd0);
        check("rst_be", 64'(ram_be), 64'd0);
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_wdata", 64'(ram_wdata), 64'd0);
        check("rst_readdata", mem_readdata, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_op(1'b0, 1'b1, 3, 64'h8000_0000_0000_0008, 64'd0, 0);
        check("octa_value", mem_readdata, 64'h1122_3344_5566_7788);
        do_op(1'b1, 1'b0, 0, 64'h0000_0000_0000_0103, 64'h0000_0000_0000_00AB, 0);
        do_op(1'b0, 1'b1, 0, 64'h0000_0000_0000_0103, 64'd0, 1);
        check("byte_value", mem_readdata, 64'h0000_0000_0000_00AB);
        do_op(1'b0, 1'b1, 2, 64'h0000_0000_0000_0006, 64'd0, 3);
        do_op(1'b1, 1'b1, 1, 64'h0000_0000_0000_0040, 64'h0000_0000_0000_BEEF, -1);

        // Abandon an octa write mid-beat; rewriting existing contents keeps the model exact.
        wait_fixed = 2;
        a0 = acks_total;
        wv = ref_read(9'h080, 8);
        push_beats(1'b1, 3, 9'h080, wv);
        mem_address = 64'h0000_0000_0000_0080;
        mem_datasize = 2'd3;
        mem_writedata = wv;
        mem_write = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = (acks_total >= a0 + 2);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_wr", 64'(ram_wr), 64'd0);
        check("rst_mid_rd", 64'(ram_rd), 64'd0);
        check("rst_mid_done", 64'(mem_done), 64'd0);
        mem_write = 1'b0;
        repeat (3) @(negedge clk);
        bq.delete();
        check("rst_mid_readdata", mem_readdata, 64'd0);
        exp_last = 64'd0;
        reset_n = 1'b1;
        @(negedge clk);
        do_op(1'b0, 1'b1, 1, 64'h0000_0000_0000_0012, 64'd0, 0);

`ifdef MMIX_MEM_TIMEOUT_EN
        check("tmo_before", 64'(mem_timeout), 64'd0);
        no_ack = 1'b1;
        do_op(1'b0, 1'b1, 1, 64'h0000_0000_0000_0020, 64'd0, 0);
        no_ack = 1'b0;
        bq.delete();
        check("tmo_flag", 64'(mem_timeout), 64'd1);
`endif

        for (int n = 0; n < 60; n++) begin
            bit wr;
            a = {$urandom, $urandom};
            a[20:9] = 12'd0;
            wr = 1'($urandom_range(1));
            do_op(wr, !wr, int'($urandom_range(3)), a, {$urandom, $urandom},
                  ($urandom_range(3) == 0) ? -1 : int'($urandom_range(2)));
        end

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("beats_drained", 64'(bq.size()), 64'd0);
`ifdef MMIX_MEM_TIMEOUT_EN
        check("tmo_sticky", 64'(mem_timeout), 64'd1);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mmix_mem_responder.md
Name: mmix_mem_responder

Overview:
- Responder end of the CPU memory bus (mem_address/mem_datasize/mem_read/mem_write/mem_writedata → mem_readdata/mem_done).
- Serves byte/wyde/tetra/octa requests against a 16-bit-wide, wait-stated, big-endian backing RAM by splitting each access into 1, 2 or 4 word beats, then pulses mem_done.
- Sits between the cpu top and the board SRAM/SDRAM controller.

Parameters:
- ADDR_W, 20, width of the backend word address; RAM spans 2^(ADDR_W+1) bytes.
- TIMEOUT, 255, max cycles waiting for ram_ack per beat (optional feature only).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- mem_address  in  64  byte address from the initiator
- mem_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- mem_read  in  1  read request level
- mem_write  in  1  write request level
- mem_writedata  in  64  write value, right-justified to size
- mem_readdata  out  64  read value, right-justified, zero-extended
- mem_done  out  1  one-cycle completion pulse
- ram_addr  out  ADDR_W  backend word address
- ram_rd  out  1  backend read strobe, held until ack
- ram_wr  out  1  backend write strobe, held until ack
- ram_be  out  2  byte enables; [1] = bits 15:8 (lower byte address)
- ram_wdata  out  16  backend write word
- ram_rdata  in  16  backend read word, valid in the ack cycle
- ram_ack  in  1  backend beat complete
- mem_timeout  out  1  sticky timeout flag (macro only; otherwise absent)

Behaviour:
- Reset (async): state IDLE; mem_done, ram_rd, ram_wr, ram_be, ram_wdata, ram_addr, mem_readdata and mem_timeout all 0.
- Address mapping: word address = mem_address[ADDR_W:1]. Bits 63..ADDR_W+1 are ignored (aliasing; the 0x8000… reset vector maps into RAM).
- Alignment follows MMIX rules; low bits are ignored by size:
  - wyde ignores bit0
  - tetra ignores [1:0]
  - octa ignores [2:0]
- States:
  - IDLE: if mem_write or mem_read is high, capture address, size, direction and writedata. Clear beat counter. Go to ACCESS. mem_write has priority when both are high.
  - ACCESS: drive ram_rd or ram_wr plus ram_addr/ram_be/ram_wdata for the current beat; hold them stable until ram_ack. On ack:
    - read: store ram_rdata into its slot
    - last beat: go to DONE
    - otherwise: beat+1 and stay in ACCESS; the strobe stays high and ram_addr advances on the next cycle
  - DONE: mem_done=1 for exactly one cycle, strobes 0, then go to IDLE.
- Beats:
  - byte = 1 beat. be=10 when addr[0]=0, be=01 when addr[0]=1. Write puts the byte on both halves of ram_wdata. Read data = {56'b0, selected byte}.
  - wyde = 1 beat, be=11.
  - tetra = 2 beats at base, base+1. Beat0 carries bits 31:16.
  - octa = 4 beats at base..base+3. Beat0 carries bits 63:48 (big-endian).
- mem_readdata is updated in the DONE cycle for reads and held until the next read's DONE. Writes leave it unchanged.
- Latency with zero-wait backend (ack on the first ACCESS cycle), counted from the IDLE sampling edge: byte/wyde mem_done after 2 cycles, tetra 3, octa 5. Each backend wait cycle adds 1.
- Turnaround: the initiator must drop its request by the edge after mem_done; a request still high in IDLE starts a new access.
- Request inputs are ignored outside IDLE. Changes mid-access have no effect.
- Reset mid-access: strobes drop immediately, the access is abandoned, and no mem_done is issued.

Optional Feature:
- Macro MMIX_MEM_TIMEOUT_EN.
- Defined: a per-beat counter runs in ACCESS. If TIMEOUT cycles pass without ram_ack, the beat is forced complete:
  - read slot filled with 16'hFFFF
  - access proceeds normally to DONE
  - mem_timeout set, sticky until reset
- Undefined: no counter, no mem_timeout port; ACCESS waits indefinitely.

Test Plan:
- Octa read at 0x...0008, RAM words 0x0004..0x0007 = 1122,3344,5566,7788, zero-wait → ram_addr sequence 4,5,6,7; mem_done 5 cycles after request; mem_readdata=0x1122334455667788.
- Byte write 0xAB to address 0x...0103 → one beat, ram_addr=0x81, be=01, ram_wdata=0xABAB; later byte read of same address returns 0x00000000000000AB.
- Tetra read at 0x...0006 (misaligned) with ack delayed 3 cycles per beat → beats at word addresses 2 and 3, strobes held stable while waiting, mem_done 9 cycles after request.
- mem_read and mem_write asserted together (wyde) → write performed with ram_wr=1, be=11; mem_readdata unchanged.
- Reset asserted during beat 2 of an octa write → ram_wr drops asynchronously, no mem_done; a fresh request after release completes normally.
- With MMIX_MEM_TIMEOUT_EN, TIMEOUT=4, ram_ack never asserted, wyde read → mem_done after 6 cycles, mem_readdata=0xFFFF, mem_timeout=1 and stays 1.
